// File: rtl/tdc_pkg.sv
// Shared OpenTDC constants, timestamp field layout and small helper functions.
// The Wishbone slice and firmware headers decode timestamps with the same layout.
package tdc_pkg;

  localparam int TDC_NTAPS_DEF    = 64;
  localparam int TDC_COARSE_W_DEF = 16;
  localparam int TDC_MAX_TAPS     = 256;

  // Timestamp word: fine code occupies the LSBs, coarse count sits directly above it.
  localparam int TDC_TS_FINE_LSB  = 0;

  function automatic int tdc_clog2(input int value);
    int result;
    result = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < value) result = k + 1;
    end
    return result;
  endfunction

  function automatic int tdc_ts_coarse_lsb(input int ntaps);
    return TDC_TS_FINE_LSB + tdc_clog2(ntaps + 1);
  endfunction

  // Counting ones rather than locating the first zero makes the fine code bubble-tolerant.
  function automatic int unsigned tdc_popcount(input logic [TDC_MAX_TAPS-1:0] value);
    int unsigned count;
    count = 0;
    for (int k = 0; k < TDC_MAX_TAPS; k++) begin
      count += {31'd0, value[k]};
    end
    return count;
  endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with flush.
// A push while full is ignored unless a pop frees the slot in the same cycle.
module tdc_sync_fifo
  import tdc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [WIDTH-1:0]          din_i,
  output logic [WIDTH-1:0]          dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [tdc_clog2(DEPTH):0] level_o
);

  localparam int AW = tdc_clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);
  assign level_o = r_count;
  assign dout_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wr_ptr] <= din_i;
  end

endmodule

// File: rtl/tdc_ts_capture.sv
// Delay-line timestamp capture: edge detect, {coarse, popcount fine} packing,
// and buffering into a FWFT FIFO with a sticky overflow flag.
module tdc_ts_capture
  import tdc_pkg::*;
#(
  parameter int NTAPS    = TDC_NTAPS_DEF,
  parameter int COARSE_W = TDC_COARSE_W_DEF,
  parameter int DEPTH    = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic [NTAPS-1:0]                          taps_i,
  input  logic                                      en_i,
  input  logic                                      clear_i,
  output logic [COARSE_W+tdc_clog2(NTAPS+1)-1:0]    ts_o,
  output logic                                      valid_o,
  input  logic                                      pop_i,
  output logic [tdc_clog2(DEPTH):0]                 level_o,
  output logic                                      overflow_o,
  output logic [COARSE_W-1:0]                       coarse_o
);

  localparam int FINE_W     = tdc_clog2(NTAPS + 1);
  localparam int TS_W       = COARSE_W + FINE_W;
  localparam int COARSE_LSB = tdc_ts_coarse_lsb(NTAPS);

  logic [COARSE_W-1:0] r_cnt;
  logic [NTAPS-1:0]    r_taps;
  logic                r_prev0;
  logic [COARSE_W-1:0] r_coarse1;
  logic                r_evt2;
  logic [FINE_W-1:0]   r_fine2;
  logic [COARSE_W-1:0] r_coarse2;
  logic                r_overflow;

  logic                w_evt;
  logic                w_full;
  logic                w_empty;
  logic                w_drop;
  logic [TS_W-1:0]     w_ts;

  assign w_evt  = r_taps[0] & ~r_prev0 & en_i;
  assign w_drop = r_evt2 & w_full & ~pop_i;

  // Forcing prev0 high on clear masks whatever edge is sampled in the clear cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt      <= '0;
      r_taps     <= '0;
      r_prev0    <= 1'b0;
      r_coarse1  <= '0;
      r_evt2     <= 1'b0;
      r_fine2    <= '0;
      r_coarse2  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_cnt     <= clear_i ? '0 : r_cnt + COARSE_W'(1);
      r_taps    <= taps_i;
      r_prev0   <= clear_i | r_taps[0];
      r_coarse1 <= r_cnt;
      r_evt2    <= w_evt & ~clear_i;
      r_fine2   <= FINE_W'(tdc_popcount(TDC_MAX_TAPS'(r_taps)));
      r_coarse2 <= r_coarse1;
      if (clear_i)     r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_ts = '0;
    w_ts[TDC_TS_FINE_LSB +: FINE_W] = r_fine2;
    w_ts[COARSE_LSB +: COARSE_W]    = r_coarse2;
  end

  tdc_sync_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (clear_i),
    .push_i  (r_evt2),
    .pop_i   (pop_i),
    .din_i   (w_ts),
    .dout_o  (ts_o),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  assign valid_o    = ~w_empty;
  assign overflow_o = r_overflow;
  assign coarse_o   = r_cnt;

endmodule

// File: doc/tdc_ts_capture.md
# tdc_ts_capture

Timestamp capture and buffering stage sitting directly downstream of the tapped delay line in each OpenTDC channel. Each clock it samples the delay-line thermometer word and detects a new rising input edge. On an edge it combines a free-running coarse counter with a thermometer-to-binary fine code, and pushes the resulting timestamp into a small FIFO. The Wishbone register slice drains that FIFO for firmware, which then checks FD→TDC loopback results over the user GPIOs.

## Interface
Parameters:
- `NTAPS`, 64, delay-line taps sampled per clock.
- `COARSE_W`, 16, coarse counter width.
- `DEPTH`, 8, FIFO entries; power of 2, ≥ 2.
- `FINE_W`, clog2(`NTAPS`+1), fine code width; derived, not overridable.

Ports:
- `clk_i`, in, 1, single clock; all state on rising edge.
- `rst_n_i`, in, 1, reset, asynchronous assert, active-low.
- `taps_i`, in, `NTAPS`, raw delay-line sample; bit 0 is nearest the input pad.
- `en_i`, in, 1, capture enable. While 0, no edges are detected; the coarse counter keeps running.
- `clear_i`, in, 1, synchronous: flush FIFO, clear `overflow_o`, reset coarse counter to 0.
- `ts_o`, out, `COARSE_W`+`FINE_W`, head-of-FIFO entry {coarse, fine}; first-word-fall-through.
- `valid_o`, out, 1, FIFO not empty; `ts_o` meaningful.
- `pop_i`, in, 1, consume head; ignored when `valid_o`=0.
- `level_o`, out, clog2(`DEPTH`)+1, current entry count.
- `overflow_o`, out, 1, sticky: at least one event was dropped.
- `coarse_o`, out, `COARSE_W`, live coarse counter, for firmware time reference.

## Operation
- **Stage 1.** Register `taps_i` into `taps_q`, and the previous sample's bit 0 into `prev0_q`. Latch `coarse_q` = counter value in the same cycle.
- **Edge detect.** The edge condition is `taps_q[0]`=1 and `prev0_q`=0 and `en_i`=1.
  - Only rising edges count.
  - A level held high produces exactly one event.
- **Fine code.** Fine code = popcount(`taps_q`), which makes it bubble-tolerant.
  - Range 0..`NTAPS`; all ones gives `NTAPS`.
  - Registered in stage 2 together with `coarse_q` and the event flag.
- **Coarse counter.** Free-running, increments every cycle. Wraps 2^`COARSE_W`−1 → 0 with no flag.
- **FIFO write.** Occurs in stage 3 when the stage-2 event flag is set.
  - If the FIFO is full and no pop happens this cycle: entry dropped, `overflow_o`←1.
  - If full and popped in the same cycle: write accepted, level stays `DEPTH`.
- **Read.**
  - `pop_i` with `valid_o`=1 removes the head.
  - Simultaneous push and pop on a non-full FIFO leaves the level unchanged.
- **`clear_i`.** Overrides everything in that cycle.
  - Empties the FIFO, clears `overflow_o`, zeroes the counter, kills in-flight pipeline events.
  - An edge sampled during `clear_i` is discarded.
- **`en_i` deassert mid-pipeline.** Events already past edge detect still complete their write.

## Timing
- Reset values (async): `valid_o`=0, `level_o`=0, `overflow_o`=0, `coarse_o`=0, `ts_o`=0. All pipeline registers are 0, including `prev0_q`.
- After reset release, `taps_i` already high on the first sample yields an event, because `prev0_q`=0.
- **Latency.** `taps_i` edge sampled at edge N appears in the FIFO at edge N+2. `valid_o` rises after edge N+2 when the FIFO was empty.
- **Coarse value.** The recorded coarse value is the counter value at edge N, the sample edge.
- **Throughput.** One event per 2 cycles at most, since edge detect needs a low sample between events. The FIFO accepts one write per cycle.
- **`ts_o`.** Stable while `valid_o`=1 and no pop; updates the cycle after a pop.

## Structure
- Shared `tdc_pkg` holds: `TDC_NTAPS_DEF`, `TDC_COARSE_W_DEF`, a clog2 function, and the timestamp field offsets (`fine` at LSBs, `coarse` above). The Wishbone slice and firmware headers use the same layout.
- Sub-module `tdc_sync_fifo`: generic synchronous FWFT FIFO (`WIDTH`, `DEPTH`, push/pop/full/empty/level, flush). Overflow policy lives in `tdc_ts_capture`, not in the FIFO.
- Popcount is a function in `tdc_pkg`.

## Test plan
- **Single edge.**
  - Stimulus: reset; hold `taps_i`=0; at counter=5 drive `taps_i`=0x000000000000000F for one cycle, then all-ones for 3 cycles, then 0.
  - Required: exactly one entry, coarse=5, fine=4, `valid_o` 2 cycles after the sample.
- **Bubble tolerance.**
  - Stimulus: after a 0 sample, `taps_i`=0x0000000000000B7F.
  - Required: fine=10.
  - Stimulus: all-ones after a 0 sample.
  - Required: fine=64.
- **Overflow.**
  - Stimulus: 9 edges with no pops (`DEPTH`=8).
  - Required: `level_o`=8, `overflow_o`=1, entries 1–8 intact in order.
  - Stimulus: `clear_i`.
  - Required: level 0, `overflow_o`=0.
- **Full with simultaneous pop.** Fill to 8; pop in the same cycle the 9th event writes. Required: level stays 8, no overflow, last entry is the 9th event.
- **Wrap.**
  - Stimulus: `COARSE_W`=4; edges at counter 15 and at counter 1 after wrap.
  - Required: coarse 15 then 1, no error.
- **Enable/reset.**
  - Stimulus: edge with `en_i`=0.
  - Required: no entry.
  - Stimulus: assert `rst_n_i` mid-pipeline with 3 entries queued.
  - Required: all outputs 0 immediately, no entry after release unless a new edge.
